panel_input_ctrl: RTL and testbench



---
 rtl/panel_input_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_panel_input_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/panel_input_ctrl.sv
// panel_input_ctrl
// Front-panel input stage: synchronises and debounces the power key and five
// panel keys, runs the power state machine (off -> startup animation -> on)
// and presents qualified, glitch-free key levels to the mode controller.
// All timing advances only on the slow `tick` strobe.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   tick     in   one-clk timing strobe; counters advance only when high
//   pwr_key  in   raw power key, active high, asynchronous
//   key_raw  in   raw panel keys: [0] light toggle, [4:1] mode keys
//   switch   out  debounced, qualified key levels (0 outside ON)
//   cando    out  1 while in ON
//   running  out  1 while in STARTUP
//   startor  out  startup animation pattern bit
module panel_input_ctrl #(
    parameter int unsigned DEBOUNCE_TICKS = 20,
    parameter int unsigned ANIM_TICKS     = 2000,
    parameter int unsigned BLINK_TICKS    = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       pwr_key,
    input  logic [4:0] key_raw,
    output logic [4:0] switch,
    output logic       cando,
    output logic       running,
    output logic       startor
);

    localparam int unsigned DbW    = $clog2(DEBOUNCE_TICKS) + 1;
    localparam int unsigned AnimW  = $clog2(ANIM_TICKS) + 1;
    localparam int unsigned BlinkW = $clog2(BLINK_TICKS) + 1;

    // Count values on which the next tick reaches the terminal count.
    localparam logic [DbW-1:0]    DbLast    = DbW'(DEBOUNCE_TICKS - 1);
    localparam logic [AnimW-1:0]  AnimLast  = AnimW'(ANIM_TICKS - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {StOff, StStartup, StOn} state_e;

    // Bit 0 is the power key, bits 5:1 are the panel keys.
    logic [5:0] raw_in;
    logic [5:0] sync1_q, sync2_q;
    logic [5:0] deb;

    assign raw_in = {key_raw, pwr_key};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < 6; i++) begin : g_deb
        logic [DbW-1:0] cnt_q;
        logic           deb_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                deb_q <= 1'b0;
            end else if (sync2_q[i] == deb_q) begin
                // Agreement (including a bounce back) restarts the count.
                cnt_q <= '0;
            end else if (tick) begin
                if (cnt_q == DbLast) begin
                    deb_q <= sync2_q[i];
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign deb[i] = deb_q;
    end

    // Power event gating. A key held through reset debounces high without an
    // event: events are armed only once the synchronised and debounced power
    // key have both been seen low after the synchroniser has refilled.
    logic [1:0] settle_q;
    logic       pwr_prev_q;
    logic       armed_q;
    logic       pwr_event;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q   <= '0;
            pwr_prev_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            settle_q   <= {settle_q[0], 1'b1};
            pwr_prev_q <= deb[0];
            if (settle_q[1] && !sync2_q[0] && !deb[0]) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign pwr_event = deb[0] & ~pwr_prev_q & armed_q;

    // Mode keys pass only when at most one is held; the light key always passes.
    logic [3:0] mode_keys;
    logic       mode_multi;
    logic [4:0] sw_qual;

    always_comb begin
        mode_keys  = deb[5:2];
        mode_multi = |(mode_keys & (mode_keys - 4'd1));
        sw_qual    = {(mode_multi ? 4'b0000 : mode_keys), deb[1]};
    end

    state_e             state_q;
    logic [AnimW-1:0]   anim_cnt_q;
    logic [BlinkW-1:0]  blink_cnt_q;
    logic [4:0]         switch_q;
    logic               cando_q;
    logic               running_q;
    logic               startor_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StOff;
            anim_cnt_q  <= '0;
            blink_cnt_q <= '0;
            switch_q    <= '0;
            cando_q     <= 1'b0;
            running_q   <= 1'b0;
            startor_q   <= 1'b0;
        end else begin
            case (state_q)
                StOff: begin
                    if (pwr_event) begin
                        state_q     <= StStartup;
                        running_q   <= 1'b1;
                        startor_q   <= 1'b1;
                        anim_cnt_q  <= '0;
                        blink_cnt_q <= '0;
                    end
                end
                StStartup: begin
                    // A power event beats the animation terminal count.
                    if (pwr_event) begin
                        state_q   <= StOff;
                        running_q <= 1'b0;
                        startor_q <= 1'b0;
                    end else if (tick) begin
                        if (anim_cnt_q == AnimLast) begin
                            state_q   <= StOn;
                            running_q <= 1'b0;
                            cando_q   <= 1'b1;
                            startor_q <= 1'b1;
                        end else begin
                            anim_cnt_q <= anim_cnt_q + 1'b1;
                            if (blink_cnt_q == BlinkLast) begin
                                startor_q   <= ~startor_q;
                                blink_cnt_q <= '0;
                            end else begin
                                blink_cnt_q <= blink_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                StOn: begin
                    if (pwr_event) begin
                        state_q   <= StOff;
                        cando_q   <= 1'b0;
                        startor_q <= 1'b0;
                        switch_q  <= '0;
                    end else begin
                        switch_q <= sw_qual;
                    end
                end
                default: begin
                    state_q   <= StOff;
                    cando_q   <= 1'b0;
                    running_q <= 1'b0;
                    startor_q <= 1'b0;
                    switch_q  <= '0;
                end
            endcase
        end
    end

    assign switch  = switch_q;
    assign cando   = cando_q;
    assign running = running_q;
    assign startor = startor_q;

endmodule

// File: tb/tb_panel_input_ctrl.sv
// Testbench for panel_input_ctrl with DEBOUNCE_TICKS=4, ANIM_TICKS=16,
// BLINK_TICKS=4. Key press latency: 2 sync edges + 4 debounce ticks puts the
// debounced level on the 6th edge after the input changes; registered
// outputs follow on the 7th.
module tb_panel_input_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       pwr_key = 1'b0;
    logic [4:0] key_raw = 5'b0;
    logic [4:0] switch;
    logic       cando;
    logic       running;
    logic       startor;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0] keys;
        int         cycles;
        logic [4:0] exp_sw;
    } vec_t;

    vec_t vecs[$];

    panel_input_ctrl #(
        .DEBOUNCE_TICKS(4),
        .ANIM_TICKS    (16),
        .BLINK_TICKS   (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .pwr_key(pwr_key),
        .key_raw(key_raw),
        .switch (switch),
        .cando  (cando),
        .running(running),
        .startor(startor)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [4:0] sw, input logic c,
                             input logic r, input logic s);
        check({name, "_switch"}, switch, sw);
        check({name, "_cando"}, {4'b0, cando}, {4'b0, c});
        check({name, "_running"}, {4'b0, running}, {4'b0, r});
        check({name, "_startor"}, {4'b0, startor}, {4'b0, s});
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // From OFF: power on, release, re-press d ticks after STARTUP entry.
    task automatic abort_run(input int d, input string name);
        pwr_key = 1'b1;
        step(7);
        check({name, "_entered"}, {4'b0, running}, 5'd1);
        pwr_key = 1'b0;
        step(d);
        pwr_key = 1'b1;
        step(6);
        check({name, "_pre"}, {4'b0, running}, 5'd1);
        step(1);
        check_all(name, 5'b0, 1'b0, 1'b0, 1'b0);
        pwr_key = 1'b0;
        step(30);
        check({name, "_stays_off"}, {3'b0, cando, running}, 5'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        // Debounce glitch filter: 2-tick pulses never qualify.
        for (int i = 0; i < 5; i++) begin
            vecs.push_back('{keys: 5'b00100, cycles: 2, exp_sw: 5'b00000});
            vecs.push_back('{keys: 5'b00000, cycles: 2, exp_sw: 5'b00000});
        end
        vecs.push_back('{keys: 5'b00100, cycles: 6, exp_sw: 5'b00000});
        vecs.push_back('{keys: 5'b00100, cycles: 1, exp_sw: 5'b00100});
        vecs.push_back('{keys: 5'b00000, cycles: 10, exp_sw: 5'b00000});
        // Two mode keys together are suppressed; releasing one lets the other through.
        vecs.push_back('{keys: 5'b10010, cycles: 10, exp_sw: 5'b00000});
        vecs.push_back('{keys: 5'b10000, cycles: 6, exp_sw: 5'b00000});
        vecs.push_back('{keys: 5'b10000, cycles: 1, exp_sw: 5'b10000});
        vecs.push_back('{keys: 5'b00000, cycles: 10, exp_sw: 5'b00000});
        // Light key is independent of the mode-key qualification.
        vecs.push_back('{keys: 5'b00011, cycles: 10, exp_sw: 5'b00011});
        vecs.push_back('{keys: 5'b01101, cycles: 10, exp_sw: 5'b00001});
        vecs.push_back('{keys: 5'b00000, cycles: 10, exp_sw: 5'b00000});

        tick = 1'b1;
        step(3);
        check_all("reset", 5'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(5);
        check_all("idle", 5'b0, 1'b0, 1'b0, 1'b0);

        // Power-on and startup animation.
        pwr_key = 1'b1;
        step(6);
        check("pre_startup_running", {4'b0, running}, 5'd0);
        step(1);
        check("startup_cando", {4'b0, cando}, 5'd0);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("startor_k%0d", k), {4'b0, startor}, {4'b0, ((k / 4) % 2) == 0});
            check($sformatf("running_k%0d", k), {4'b0, running}, 5'd1);
            if (k == 4) pwr_key = 1'b0;
            step(1);
        end
        check_all("on_entry", 5'b0, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            key_raw = vecs[i].keys;
            step(vecs[i].cycles);
            check($sformatf("vec%0d", i), switch, vecs[i].exp_sw);
            check($sformatf("vec%0d_cando", i), {4'b0, cando}, 5'd1);
        end

        // Shutdown drops cando and switch on the same edge; OFF gates keys.
        key_raw = 5'b00001;
        step(10);
        check("light_on", switch, 5'b00001);
        pwr_key = 1'b1;
        step(6);
        check("pre_off_cando", {4'b0, cando}, 5'd1);
        check("pre_off_switch", switch, 5'b00001);
        step(1);
        check_all("off", 5'b0, 1'b0, 1'b0, 1'b0);
        step(10);
        check("off_gated", switch, 5'b0);
        pwr_key = 1'b0;
        step(10);
        check("off_gated2", switch, 5'b0);
        pwr_key = 1'b1;
        step(7);
        check("relaunch_running", {4'b0, running}, 5'd1);
        pwr_key = 1'b0;
        step(16);
        check_all("reentry", 5'b0, 1'b1, 1'b0, 1'b1);
        step(1);
        check("held_key_passes", switch, 5'b00001);
        key_raw = 5'b0;
        pwr_key = 1'b1;
        step(7);
        check_all("off2", 5'b0, 1'b0, 1'b0, 1'b0);
        pwr_key = 1'b0;
        step(10);

        // Aborts: mid-animation, and coincident with the terminal count.
        abort_run(6, "abort_mid");
        abort_run(9, "abort_terminal");

        // Reset mid-STARTUP with the power key held.
        pwr_key = 1'b1;
        step(7);
        check("rst_pre_running", {4'b0, running}, 5'd1);
        #2 rst_n = 1'b0;
        #1 check_all("async_reset", 5'b0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        step(30);
        check_all("held_through_reset", 5'b0, 1'b0, 1'b0, 1'b0);
        pwr_key = 1'b0;
        step(12);
        pwr_key = 1'b1;
        step(6);
        check("repress_pre", {4'b0, running}, 5'd0);
        step(1);
        check("repress_running", {4'b0, running}, 5'd1);

        // Stall tick inside STARTUP: animation must freeze.
        tick = 1'b0;
        step(30);
        check_all("stalled", 5'b0, 1'b0, 1'b1, 1'b1);
        tick = 1'b1;
        pwr_key = 1'b0;
        step(15);
        check("resume_running", {4'b0, running}, 5'd1);
        step(1);
        check_all("resume_on", 5'b0, 1'b1, 1'b0, 1'b1);

        // Reset with tick stalled and the key held.
        tick = 1'b0;
        pwr_key = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_all("reset_stalled", 5'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
